// File: rtl/matrix_storage_pkg.sv
// Shared constants, reader state encoding and dimension clamp for matrix_storage.
package matrix_storage_pkg;

   localparam int MAX_DIM   = 5;
   localparam int MAX_ELEMS = 25;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } rd_state_t;

   // Limit a stored dimension to the 5x5 element grid.
   function automatic logic [2:0] clamp_dim(input logic [2:0] d);
      return (d > 3'(MAX_DIM)) ? 3'(MAX_DIM) : d;
   endfunction

endpackage

// File: rtl/matrix_stream_reader.sv
// Reader FSM for matrix_storage: latches slot dimensions on start, walks the
// r/c counters row-major and produces the element handshake and status pulses.
module matrix_stream_reader
   import matrix_storage_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rd_start,
   input  logic       start_ok,
   input  logic [2:0] start_row,
   input  logic [2:0] start_col,
   input  logic [2:0] rd_idx,
   input  logic       elem_ready,
   output logic       rd_busy,
   output logic [2:0] rd_row,
   output logic [2:0] rd_col,
   output logic       elem_valid,
   output logic       elem_last,
   output logic [2:0] elem_r,
   output logic [2:0] elem_c,
   output logic [4:0] elem_addr,
   output logic [2:0] cur_idx,
   output logic       rd_done,
   output logic       rd_err
);

   rd_state_t  state, state_nx;
   logic [2:0] r_q, c_q, row_q, col_q, idx_q;
   logic       err_q, empty, at_last, xfer, launch;

   assign empty   = (row_q == 3'd0) || (col_q == 3'd0);
   assign at_last = (r_q == row_q - 3'd1) && (c_q == col_q - 3'd1);
   assign launch  = (state == IDLE) && rd_start && start_ok;

   assign rd_busy    = (state == STREAM);
   assign elem_valid = (state == STREAM) && !empty;
   assign elem_last  = elem_valid && at_last;
   assign xfer       = elem_valid && elem_ready;
   assign rd_done    = (state == DONE);
   assign rd_err     = err_q;
   assign rd_row     = row_q;
   assign rd_col     = col_q;
   assign elem_r     = r_q;
   assign elem_c     = c_q;
   assign cur_idx    = idx_q;
   // r*5+c; r,c <= 4 keeps the sum at most 24
   assign elem_addr  = ({2'b00, r_q} << 2) + {2'b00, r_q} + {2'b00, c_q};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state: an empty slot passes through STREAM for one cycle without data
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (launch) state_nx = STREAM;
         STREAM:  if (empty || (xfer && at_last)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Dimension latch, row-major counters and the refused-start pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q   <= '0;
         c_q   <= '0;
         row_q <= '0;
         col_q <= '0;
         idx_q <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= (state == IDLE) && rd_start && !start_ok;
         if (launch) begin
            row_q <= start_row;
            col_q <= start_col;
            idx_q <= rd_idx;
            r_q   <= '0;
            c_q   <= '0;
         end else if (xfer && !at_last) begin
            if (c_q == col_q - 3'd1) begin
               c_q <= '0;
               r_q <= r_q + 3'd1;
            end else begin
               c_q <= c_q + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/matrix_storage.sv
// Multi-slot matrix store (up to 5x5 elements per slot) with a streamed reader.
// Optional MATRIX_STORAGE_DIM_CHECK_EN: refuse writes whose rows/cols are 0 or >5;
// otherwise dimensions are stored as given and clamped to 5 on read.
module matrix_storage
   import matrix_storage_pkg::*;
#(
   parameter int SLOTS = 8,
   parameter int DW    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [2:0]             wr_idx,
   input  logic [2:0]             wr_row,
   input  logic [2:0]             wr_col,
   input  logic [MAX_ELEMS*DW-1:0] wr_data,
   output logic                   wr_rej,
   input  logic                   clr_all,
   output logic [SLOTS-1:0]       slot_valid,
   input  logic                   rd_start,
   input  logic [2:0]             rd_idx,
   output logic                   rd_busy,
   output logic [2:0]             rd_row,
   output logic [2:0]             rd_col,
   output logic                   elem_valid,
   output logic                   elem_last,
   output logic [DW-1:0]          elem_data,
   output logic [2:0]             elem_r,
   output logic [2:0]             elem_c,
   input  logic                   elem_ready,
   output logic                   rd_done,
   output logic                   rd_err
);

   // Elements live on a fixed 5-wide grid so the reader address is r*5+c.
   logic [DW-1:0] mem   [SLOTS][MAX_ELEMS];
   logic [2:0]    dim_r [SLOTS];
   logic [2:0]    dim_c [SLOTS];

   logic       wr_in_range, rd_in_range, dim_ok, wr_ok, wr_to_rd, start_ok;
   logic [2:0] wr_rc, wr_cc, start_row, start_col, cur_idx;
   logic [4:0] elem_addr;

   assign wr_in_range = (int'(wr_idx) < SLOTS);
   assign rd_in_range = (int'(rd_idx) < SLOTS);

`ifdef MATRIX_STORAGE_DIM_CHECK_EN
   assign dim_ok = (wr_row != 3'd0) && (wr_row <= 3'(MAX_DIM)) &&
                   (wr_col != 3'd0) && (wr_col <= 3'(MAX_DIM));
`else
   assign dim_ok = 1'b1;
`endif

   // The slot under readout is frozen until the stream leaves STREAM
   assign wr_ok = wr_en && wr_in_range && dim_ok && !(rd_busy && (wr_idx == cur_idx));
   assign wr_rc = clamp_dim(wr_row);
   assign wr_cc = clamp_dim(wr_col);

   // A same-cycle write to the slot being started wins: forward its dimensions
   assign wr_to_rd  = wr_ok && (wr_idx == rd_idx);
   assign start_ok  = rd_in_range && (wr_to_rd || slot_valid[rd_idx]);
   assign start_row = wr_to_rd ? wr_rc : clamp_dim(dim_r[rd_idx]);
   assign start_col = wr_to_rd ? wr_cc : clamp_dim(dim_c[rd_idx]);

   // Slot flags, stored dimensions and the write-refused pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid <= '0;
         wr_rej     <= 1'b0;
         for (int s = 0; s < SLOTS; s++) begin
            dim_r[s] <= '0;
            dim_c[s] <= '0;
         end
      end else begin
         wr_rej <= wr_en && !wr_ok;
         if (clr_all) slot_valid <= '0;
         if (wr_ok) begin
            slot_valid[wr_idx] <= 1'b1;
            dim_r[wr_idx]      <= wr_row;
            dim_c[wr_idx]      <= wr_col;
         end
      end
   end

   // Scatter packed row-major input (stride wr_col) onto the 5-wide grid
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
               if ((r < int'(wr_rc)) && (c < int'(wr_cc)))
                  mem[wr_idx][r*MAX_DIM+c] <= wr_data[(r*int'(wr_cc)+c)*DW +: DW];
            end
         end
      end
   end

   // Data is zero whenever no element is offered, so reset shows 0
   assign elem_data = elem_valid ? mem[cur_idx][elem_addr] : '0;

   matrix_stream_reader u_reader (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_start   (rd_start),
      .start_ok   (start_ok),
      .start_row  (start_row),
      .start_col  (start_col),
      .rd_idx     (rd_idx),
      .elem_ready (elem_ready),
      .rd_busy    (rd_busy),
      .rd_row     (rd_row),
      .rd_col     (rd_col),
      .elem_valid (elem_valid),
      .elem_last  (elem_last),
      .elem_r     (elem_r),
      .elem_c     (elem_c),
      .elem_addr  (elem_addr),
      .cur_idx    (cur_idx),
      .rd_done    (rd_done),
      .rd_err     (rd_err)
   );

endmodule

// File: tb/tb_matrix_storage.sv
// Directed bench for matrix_storage: table of write/read vectors plus
// hand sequences for stalls, write conflicts, clear, empty slots and reset.
module tb_matrix_storage;

   localparam int SLOTS = 8;
   localparam int DW    = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            wr_en, clr_all, rd_start, elem_ready;
   logic [2:0]      wr_idx, wr_row, wr_col, rd_idx;
   logic [25*DW-1:0] wr_data;
   logic            wr_rej, rd_busy, elem_valid, elem_last, rd_done, rd_err;
   logic [SLOTS-1:0] slot_valid;
   logic [2:0]      rd_row, rd_col, elem_r, elem_c;
   logic [DW-1:0]   elem_data;

   int total = 0;
   int bad   = 0;

   matrix_storage #(.SLOTS(SLOTS), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_row(wr_row),
      .wr_col(wr_col), .wr_data(wr_data), .wr_rej(wr_rej), .clr_all(clr_all),
      .slot_valid(slot_valid), .rd_start(rd_start), .rd_idx(rd_idx), .rd_busy(rd_busy),
      .rd_row(rd_row), .rd_col(rd_col), .elem_valid(elem_valid), .elem_last(elem_last),
      .elem_data(elem_data), .elem_r(elem_r), .elem_c(elem_c), .elem_ready(elem_ready),
      .rd_done(rd_done), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int       idx;
      int       row;
      int       col;
      int       base;
      logic [3:0] pat;
      int       exp_n;
      int       exp_r;
      int       exp_c;
      bit       exp_rej;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, req, $time);
      end
   endtask

   task automatic load_data(input int base);
      for (int k = 0; k < 25; k++) wr_data[k*DW +: DW] = DW'(base + k);
   endtask

   task automatic do_write(input int idx, input int row, input int col, input int base,
                           input bit exp_rej);
      @(negedge clk);
      wr_en = 1'b1; wr_idx = 3'(idx); wr_row = 3'(row); wr_col = 3'(col);
      load_data(base);
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      chk("wr_rej", wr_rej, exp_rej);
   endtask

   task automatic start_read(input int idx, input bit ok, input int er, input int ec);
      @(negedge clk);
      rd_start = 1'b1; rd_idx = 3'(idx); elem_ready = 1'b0;
      @(negedge clk);
      rd_start = 1'b0;
      #1;
      if (ok) begin
         chk("start_busy", rd_busy, 1);
         chk("start_row", rd_row, er);
         chk("start_col", rd_col, ec);
         chk("start_err", rd_err, 0);
      end else begin
         chk("rd_err", rd_err, 1);
         chk("err_busy", rd_busy, 0);
      end
   endtask

   // Value of element n is base+n; data is checked on every valid cycle,
   // so a value drifting during a stall is caught too.
   task automatic drain(input int base, input int nexp, input int ecol,
                        input logic [3:0] pat, output int dcyc);
      int  n;
      bit  done;
      n = 0; done = 1'b0; dcyc = -1;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         elem_ready = pat[cyc % 4];
         #1;
         if (rd_done) begin
            done = 1'b1; dcyc = cyc;
            chk("done_busy", rd_busy, 0);
            chk("done_valid", elem_valid, 0);
            break;
         end
         if (elem_valid) begin
            chk("elem_data", int'(elem_data), base + n);
            chk("elem_r", elem_r, (ecol == 0) ? 0 : n / ecol);
            chk("elem_c", elem_c, (ecol == 0) ? 0 : n % ecol);
            chk("elem_last", elem_last, (n == nexp - 1) ? 1 : 0);
            if (elem_ready) n++;
         end
      end
      elem_ready = 1'b0;
      chk("done_seen", done, 1);
      chk("elem_count", n, nexp);
   endtask

   initial begin
      int  dc, n;
      bit  hit;

      tbl[0] = '{2, 2, 3,   1, 4'b1111,  6, 2, 3, 1'b0};
      tbl[1] = '{4, 3, 3,  10, 4'b1001,  9, 3, 3, 1'b0};
      tbl[2] = '{7, 5, 5, 100, 4'b1111, 25, 5, 5, 1'b0};
      tbl[3] = '{1, 1, 1, 200, 4'b0101,  1, 1, 1, 1'b0};
`ifdef MATRIX_STORAGE_DIM_CHECK_EN
      tbl[4] = '{6, 6, 2,  50, 4'b1111,  0, 0, 0, 1'b1};
`else
      tbl[4] = '{6, 6, 2,  50, 4'b1111, 10, 5, 2, 1'b0};
`endif
      tbl[5] = '{0, 5, 1,  30, 4'b0011,  5, 5, 1, 1'b0};

      rst_n = 1'b0; wr_en = 1'b0; clr_all = 1'b0; rd_start = 1'b0; elem_ready = 1'b0;
      wr_idx = '0; wr_row = '0; wr_col = '0; rd_idx = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_slot_valid", int'(slot_valid), 0);
      chk("rst_busy", rd_busy, 0);
      chk("rst_evalid", elem_valid, 0);
      chk("rst_elast", elem_last, 0);
      chk("rst_edata", int'(elem_data), 0);
      chk("rst_rd_row", rd_row, 0);
      chk("rst_rd_col", rd_col, 0);
      chk("rst_wr_rej", wr_rej, 0);
      chk("rst_done", rd_done, 0);
      chk("rst_err", rd_err, 0);
      rst_n = 1'b1;

      // unwritten slot -> error pulse, one cycle wide
      start_read(5, 1'b0, 0, 0);
      @(negedge clk); #1;
      chk("err_pulse_end", rd_err, 0);
      chk("err_idle_busy", rd_busy, 0);

      for (int i = 0; i < 6; i++) begin
         do_write(tbl[i].idx, tbl[i].row, tbl[i].col, tbl[i].base, tbl[i].exp_rej);
         chk("slot_valid_wr", slot_valid[tbl[i].idx], tbl[i].exp_rej ? 0 : 1);
         if (tbl[i].exp_rej) begin
            start_read(tbl[i].idx, 1'b0, 0, 0);
         end else begin
            start_read(tbl[i].idx, 1'b1, tbl[i].exp_r, tbl[i].exp_c);
            drain(tbl[i].base, tbl[i].exp_n, tbl[i].exp_c, tbl[i].pat, dc);
         end
      end

      // write to the slot being streamed is refused, other slot accepted
      start_read(2, 1'b1, 2, 3);
      do_write(2, 2, 3, 90, 1'b1);
      chk("conflict_hold", int'(elem_data), 1);
      do_write(3, 1, 1, 60, 1'b0);
      chk("other_slot_valid", slot_valid[3], 1);
      drain(1, 6, 3, 4'b1111, dc);

      // write and start on the same slot in one cycle: new data is streamed
      @(negedge clk);
      wr_en = 1'b1; wr_idx = 3'd2; wr_row = 3'd2; wr_col = 3'd2; load_data(40);
      rd_start = 1'b1; rd_idx = 3'd2;
      @(negedge clk);
      wr_en = 1'b0; rd_start = 1'b0;
      #1;
      chk("same_wr_rej", wr_rej, 0);
      chk("same_busy", rd_busy, 1);
      chk("same_row", rd_row, 2);
      chk("same_col", rd_col, 2);
      drain(40, 4, 2, 4'b1111, dc);

      // clr_all mid-stream: flags drop, simultaneous write keeps its slot, stream continues
      start_read(4, 1'b1, 3, 3);
      @(negedge clk);
      clr_all = 1'b1;
      wr_en = 1'b1; wr_idx = 3'd0; wr_row = 3'd1; wr_col = 3'd2; load_data(70);
      @(negedge clk);
      clr_all = 1'b0; wr_en = 1'b0;
      #1;
      chk("clr_slot_valid", int'(slot_valid), 1);
      chk("clr_busy", rd_busy, 1);
      drain(10, 9, 3, 4'b1111, dc);

      // zero-dimension slot
`ifdef MATRIX_STORAGE_DIM_CHECK_EN
      do_write(5, 0, 3, 0, 1'b1);
      chk("zero_slot_valid", slot_valid[5], 0);
`else
      do_write(5, 0, 3, 0, 1'b0);
      start_read(5, 1'b1, 0, 3);
      chk("zero_no_elem", elem_valid, 0);
      chk("zero_no_done_yet", rd_done, 0);
      drain(0, 0, 3, 4'b1111, dc);
      chk("zero_done_cycle", dc, 0);
`endif

      // reset during the 4th element of a 5x5 stream
      do_write(7, 5, 5, 100, 1'b0);
      start_read(7, 1'b1, 5, 5);
      n = 0; hit = 1'b0;
      for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
         @(negedge clk);
         elem_ready = 1'b1;
         #1;
         if (elem_valid) begin
            if (n == 3) begin
               chk("rst_pre_data", int'(elem_data), 103);
               rst_n = 1'b0;
               #1;
               chk("rst_mid_evalid", elem_valid, 0);
               chk("rst_mid_slots", int'(slot_valid), 0);
               chk("rst_mid_busy", rd_busy, 0);
               chk("rst_mid_edata", int'(elem_data), 0);
               hit = 1'b1;
            end else begin
               n++;
            end
         end
      end
      chk("rst_mid_reached", hit, 1);
      elem_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rst_mid_no_done", rd_done, 0);
      end
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_done", rd_done, 0);
      chk("post_rst_busy", rd_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
